// File: rtl/gpio_loop_pkg.sv
// Shared types and default timing constants for the GPIO loopback checker.
package gpio_loop_pkg;

  localparam int DEF_HALF_PERIOD = 1024;
  localparam int DEF_TOL         = 4;
  localparam int DEF_LOCK_COUNT  = 8;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_signal.sv
// N-stage flop synchronizer for asynchronous inputs; stages reset to 0.
// N must be at least 2.
module sync_signal #(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [N-1:0][WIDTH-1:0] stg_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!reset_n) stg_q <= '0;
    else          stg_q <= {stg_q[N-2:0], d_i};
  end

  assign q_o = stg_q[N-1];

endmodule

// File: rtl/gpio_loop_checker.sv
// Measures edge-to-edge intervals of a looped-back GPIO square wave, locks
// after LOCK_COUNT consecutive good intervals and counts errors once locked.
module gpio_loop_checker
  import gpio_loop_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_sig,
  input  logic             enable,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] last_interval,
  output logic             level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LO      = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_COUNT);

  logic             sync_lvl;
  logic             prev_q, edge_q;
  logic [2:0]       arm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] good_q, last_q, err_q, err_d;
  state_e           state_q;
  logic             locked_q, err_pulse_q;
  logic             good_iv, timeout, err_ev;

  sync_signal #(.WIDTH(1), .N(2)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_sig),
    .q_o     (sync_lvl)
  );

  // Registered either-edge detect. arm_q holds off edge reporting until the
  // synchronizer and prev_q have filled, so a pin already high at reset
  // release does not look like an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      prev_q <= sync_lvl;
      arm_q  <= {arm_q[1:0], 1'b1};
      edge_q <= arm_q[2] & (sync_lvl ^ prev_q);
    end
  end

  // Interval counter: restarts at 1 after an edge, otherwise saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_q)                cnt_d = ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Interval evaluation and error-event decode; an edge beats a timeout.
  always_comb begin
    good_iv = (cnt_q >= LO) && (cnt_q <= HI);
    timeout = (cnt_q == TMO) && !edge_q;
    err_ev  = enable && (state_q == ST_LOCKED) &&
              ((edge_q && !good_iv) || timeout);
    err_d   = err_q;
    if (clear)                        err_d = '0;
    else if (err_ev && err_q != CNT_MAX) err_d = err_q + ONE;
  end

  // Lock FSM with registered locked/err_pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      good_q      <= '0;
      last_q      <= '0;
      err_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      err_pulse_q <= err_ev;
      if (!enable) begin
        state_q  <= ST_IDLE;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else if (edge_q) begin
        last_q <= cnt_q;
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQUIRE;
            good_q  <= '0;
          end
          ST_ACQUIRE: begin
            if (good_iv) begin
              good_q <= good_q + ONE;
              if (good_q + ONE == LOCK_N) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (!good_iv) begin
              state_q  <= ST_ACQUIRE;
              good_q   <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end else if (timeout) begin
        state_q  <= ST_IDLE;
        good_q   <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  assign locked        = locked_q;
  assign err_pulse     = err_pulse_q;
  assign err_count     = err_q;
  assign last_interval = last_q;
  assign level         = sync_lvl;

endmodule

// File: doc/gpio_loop_checker.md
GPIO_LOOP_CHECKER -- requirements
Module: gpio_loop_checker

Interface
REQ-001 Parameter HALF_PERIOD, default 1024: expected clk cycles between consecutive input edges.
REQ-002 Parameter TOL, default 4: allowed ± deviation in cycles from HALF_PERIOD.
REQ-003 Parameter LOCK_COUNT, default 8: consecutive in-tolerance intervals required to lock.
REQ-004 Parameter CNT_W, default 16: width of the interval counter and the error counter.
REQ-005 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset_n  input  1: synchronous, active-low reset.
REQ-007 Port in_sig  input  1: asynchronous loopback square wave from the pin.
REQ-008 Port enable  input  1: checker runs when 1; when 0, returns to IDLE.
REQ-009 Port clear  input  1: single-cycle pulse; zeroes err_count.
REQ-010 Port locked  output  1: 1 while in the LOCKED state.
REQ-011 Port err_pulse  output  1: one-cycle strobe for each error event.
REQ-012 Port err_count  output  CNT_W: saturating count of error events.
REQ-013 Port last_interval  output  CNT_W: most recently measured edge-to-edge interval.
REQ-014 Port level  output  1: synchronized in_sig, intended for LED display.

Function
REQ-015 in_sig SHALL pass through a 2-flop synchronizer, then a 1-flop edge-detect register; either edge SHALL count as an edge.
REQ-016 Interval counter: reset to 1 on the cycle after an edge, otherwise increment and saturate at 2^CNT_W-1. With a clean 1024-cycle half period, every interval SHALL read exactly 1024.
REQ-017 On each edge, last_interval SHALL be loaded with the counter value, visible on the following cycle.
REQ-018 An interval is "good" when HALF_PERIOD-TOL <= interval <= HALF_PERIOD+TOL, compared unsigned and inclusive.
REQ-019 States are IDLE, ACQUIRE and LOCKED.
  - IDLE: go to ACQUIRE on the first edge while enable=1; that first edge only starts the counter and is not evaluated.
  - ACQUIRE: a good interval increments good_cnt; a bad interval zeroes good_cnt, with no error event. Go to LOCKED when good_cnt reaches LOCK_COUNT.
  - LOCKED: a bad interval produces an error event, zeroes good_cnt and goes to ACQUIRE.
  - Timeout: counter reaching 2*HALF_PERIOD with no edge goes to IDLE from any state. It is an error event only when leaving LOCKED.
REQ-020 Error event: err_pulse=1 for exactly one cycle, and err_count increments, saturating at 2^CNT_W-1.
REQ-021 enable=0 SHALL force IDLE on the next cycle and zero good_cnt; err_count and last_interval are held.
REQ-022 clear and an error event in the same cycle: clear wins, err_count=0 and err_pulse=1.
REQ-023 An edge and a timeout in the same cycle: the edge wins, and the interval is evaluated normally.
REQ-024 locked SHALL be registered and reflect the state in the same cycle that state is entered.
REQ-025 Latency from a pin transition to the state/err_pulse update SHALL be 4 clk cycles (2 sync + 1 edge + 1 state).

Reset
REQ-026 On reset_n=0 at a clk edge: state=IDLE, good_cnt=0, counter=0, err_count=0, last_interval=0, locked=0, err_pulse=0.
REQ-027 Synchronizer and edge flops SHALL reset to 0, so level=0; no spurious edge SHALL be reported if in_sig=1 at reset release (edge flop loaded from sync on first cycle out of reset).
REQ-028 Reset asserted mid-operation SHALL abort with no err_pulse.

Structure
REQ-029 The shared package gpio_loop_pkg SHALL hold the state enum and default HALF_PERIOD/TOL/LOCK_COUNT constants.
REQ-030 The synchronizer SHALL be the existing sync_signal sub-module (WIDTH=1, N=2); all other logic is in one module.

Verification
REQ-031 Input toggling every 1024 cycles, enable=1 -> locked=1 after the 9th edge (8 good intervals), err_count=0, last_interval=1024.
REQ-032 Locked, then one half period of 1030 -> one err_pulse, err_count=1, locked=0; relock after 8 further good intervals.
REQ-033 Locked, input stuck for 2048+ cycles -> err_pulse at counter=2048, state IDLE, err_count+1; same stall while in ACQUIRE -> IDLE with no error.
REQ-034 Intervals of 1020 and 1028 (boundary) -> treated as good and lock; 1019 in ACQUIRE -> good_cnt reset, no error.
REQ-035 clear pulsed in the same cycle as an error event -> err_count=0 and err_pulse=1; enable dropped while locked -> locked=0 next cycle, no error.
REQ-036 Force err_count to 2^16-1 and inject an error -> err_count stays 65535; reset_n=0 mid-lock -> all outputs 0 next cycle.
